test_scheduler: RTL and testbench
=================================

# test_scheduler

Parametrised, self-checking test sequencer for processor-level regression. It replaces hand-commented instantiation of tests by launching up to NUM_TESTS test channels one at a time through a start/done handshake, and records per-test pass/fail/timeout status. It sits at the top of the simulation hierarchy beside the clock generator and drives each test module's start input. Status vectors are read by the bench or dumped at the end of the run.

## Interface
- NUM_TESTS, 8: number of test channels (1..32).
- CNT_W, 16: width of the per-test cycle counter.
- TIMEOUT, 1000: cycles allowed in WAIT before a test is declared hung; must be less than 2^CNT_W.
- clk  in  1  system clock, rising-edge active.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; sampled in IDLE/FINISH to begin a pass.
- enable_mask  in  NUM_TESTS  tests to execute; latched when run is accepted.
- done  in  NUM_TESTS  per-test completion pulse/level.
- pass  in  NUM_TESTS  per-test verdict, valid when the matching done is high.
- start  out  NUM_TESTS  one-hot single-cycle launch pulse.
- busy  out  1  high from run acceptance until FINISH.
- finished  out  1  high in FINISH.
- current_idx  out  $clog2(NUM_TESTS+1)  index under execution; NUM_TESTS when exhausted.
- pass_vec / fail_vec / timeout_vec  out  NUM_TESTS each  recorded results.
- cycles_last  out  CNT_W  WAIT-cycle count of the most recently recorded test.
- all_passed  out  1  finished and fail_vec==0 and pass_vec==latched mask.

## Operation
- States: IDLE, SELECT, LAUNCH, WAIT, FINISH.
- IDLE/FINISH: on run=1, clear pass/fail/timeout vectors, latch enable_mask, idx=0, go to SELECT. FINISH holds otherwise.
- SELECT: idx==NUM_TESTS goes to FINISH; mask[idx]==0 increments idx and stays in SELECT (one cycle per skipped test); otherwise goes to LAUNCH.
- LAUNCH: start[idx]=1 for this cycle only, counter=0, go to WAIT.
- WAIT: done[idx]=1 sets pass_vec[idx]=pass[idx] and fail_vec[idx]=~pass[idx], cycles_last=counter, idx+1, go to SELECT. Otherwise counter increments and saturates at all-ones.
- Only done/pass of the current idx are observed. Other bits, and any done during SELECT/LAUNCH, are ignored.
- All outputs are registered. Reset value is 0 for every output, state is IDLE, and idx is 0. Reset mid-run aborts immediately, and start drops in the same edge.

## Timing
- run sampled at edge N gives SELECT at N+1 and start pulse during cycle N+2 (first test enabled).
- Minimum per-test cost: SELECT, LAUNCH, and one WAIT cycle. done high in the first WAIT cycle records cycles_last=0.
- Result bits update on the edge that leaves WAIT. The next start follows two cycles later.
- finished/all_passed rise one cycle after SELECT sees idx==NUM_TESTS.
- Empty mask: FINISH reached NUM_TESTS+1 cycles after acceptance, with all_passed=1.

## Configuration
- TEST_SCHEDULER_TIMEOUT_EN defined: in WAIT, counter==TIMEOUT-1 without done sets timeout_vec[idx]=1 and fail_vec[idx]=1, with cycles_last=TIMEOUT-1, then advances. If done and timeout occur in the same cycle, done wins.
- Undefined: no watchdog, so WAIT persists until done. timeout_vec is tied to 0 and the TIMEOUT parameter is unused.

## Test plan
- NUM_TESTS=4, mask=4'b1111, each done 3 cycles after its start with pass=1: four start pulses in order 0..3; pass_vec=1111, fail_vec=0, all_passed=1, cycles_last=2.
- Mask=4'b0101, test 2 returns pass=0: start seen only on bits 0 and 2; pass_vec=0001, fail_vec=0100, all_passed=0.
- Timeout enabled, TIMEOUT=10, test 1 never asserts done: timeout_vec=0010, fail_vec=0010, cycles_last=9, and test 2 still launched.
- Spurious done[3] asserted while test 0 is in WAIT: no effect; test 3 later records its own verdict correctly.
- Reset asserted during WAIT of test 2: next cycle all outputs are 0, state is IDLE, and no start is pulsed until run.
- Mask=0 with run held: finished after 5 cycles with all_passed=1. run kept high in FINISH restarts the pass with cleared vectors.

Source files
------------

// File: rtl/test_scheduler.sv
// Sequential test launcher: runs enabled test channels one at a time via start/done and records pass/fail/timeout per channel.
// Optional watchdog on hung tests is compiled in with TEST_SCHEDULER_TIMEOUT_EN.
module test_scheduler #(
  parameter int NUM_TESTS = 8,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               run,
  input  logic [NUM_TESTS-1:0]               enable_mask,
  input  logic [NUM_TESTS-1:0]               done,
  input  logic [NUM_TESTS-1:0]               pass,
  output logic [NUM_TESTS-1:0]               start,
  output logic                               busy,
  output logic                               finished,
  output logic [$clog2(NUM_TESTS+1)-1:0]     current_idx,
  output logic [NUM_TESTS-1:0]               pass_vec,
  output logic [NUM_TESTS-1:0]               fail_vec,
  output logic [NUM_TESTS-1:0]               timeout_vec,
  output logic [CNT_W-1:0]                   cycles_last,
  output logic                               all_passed
);

  localparam int IDX_W = $clog2(NUM_TESTS + 1);

  if (NUM_TESTS < 1 || NUM_TESTS > 32) begin : g_bad_num_tests
    $error("test_scheduler: NUM_TESTS must be in 1..32");
  end
  if (TIMEOUT < 1 || longint'(TIMEOUT) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
    $error("test_scheduler: TIMEOUT must be in 1..2^CNT_W-1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LAUNCH,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [NUM_TESTS-1:0] r_mask, w_mask_nxt;
  logic [NUM_TESTS-1:0] r_start, w_start_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_TESTS-1:0] r_pass_vec, w_pass_nxt;
  logic [NUM_TESTS-1:0] r_fail_vec, w_fail_nxt;
  logic [NUM_TESTS-1:0] r_timeout_vec, w_timeout_nxt;
  logic [CNT_W-1:0]     r_cycles_last, w_cycles_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_finished, w_finished_nxt;
  logic                 r_all_passed, w_all_passed_nxt;

  // Decoded current channel; all-zero once r_idx reaches NUM_TESTS.
  logic [NUM_TESTS-1:0] w_onehot;
  logic                 w_cur_en;
  logic                 w_cur_done;
  logic                 w_cur_pass;
  logic                 w_at_end;
  logic                 w_timeout_hit;

  assign w_onehot   = NUM_TESTS'(1) << r_idx;
  assign w_cur_en   = |(r_mask & w_onehot);
  assign w_cur_done = |(done & w_onehot);
  assign w_cur_pass = |(pass & w_onehot);
  assign w_at_end   = (r_idx == IDX_W'(NUM_TESTS));

`ifdef TEST_SCHEDULER_TIMEOUT_EN
  assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_mask_nxt       = r_mask;
    w_start_nxt      = '0;
    w_cnt_nxt        = r_cnt;
    w_pass_nxt       = r_pass_vec;
    w_fail_nxt       = r_fail_vec;
    w_timeout_nxt    = r_timeout_vec;
    w_cycles_nxt     = r_cycles_last;
    w_busy_nxt       = r_busy;
    w_finished_nxt   = r_finished;
    w_all_passed_nxt = r_all_passed;

    unique case (r_state)
      S_IDLE, S_FINISH: begin
        if (run) begin
          w_state_nxt      = S_SELECT;
          w_idx_nxt        = '0;
          w_mask_nxt       = enable_mask;
          w_pass_nxt       = '0;
          w_fail_nxt       = '0;
          w_timeout_nxt    = '0;
          w_busy_nxt       = 1'b1;
          w_finished_nxt   = 1'b0;
          w_all_passed_nxt = 1'b0;
        end
      end

      S_SELECT: begin
        if (w_at_end) begin
          w_state_nxt      = S_FINISH;
          w_busy_nxt       = 1'b0;
          w_finished_nxt   = 1'b1;
          w_all_passed_nxt = (r_fail_vec == '0) && (r_pass_vec == r_mask);
        end else if (!w_cur_en) begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end else begin
          // start is registered, so it is high exactly during the LAUNCH cycle
          w_state_nxt = S_LAUNCH;
          w_start_nxt = w_onehot;
        end
      end

      S_LAUNCH: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end

      S_WAIT: begin
        if (w_cur_done) begin
          w_pass_nxt   = r_pass_vec | (w_cur_pass ? w_onehot : '0);
          w_fail_nxt   = r_fail_vec | (w_cur_pass ? '0 : w_onehot);
          w_cycles_nxt = r_cnt;
          w_idx_nxt    = r_idx + IDX_W'(1);
          w_state_nxt  = S_SELECT;
        end else if (w_timeout_hit) begin
          w_timeout_nxt = r_timeout_vec | w_onehot;
          w_fail_nxt    = r_fail_vec | w_onehot;
          w_cycles_nxt  = r_cnt;
          w_idx_nxt     = r_idx + IDX_W'(1);
          w_state_nxt   = S_SELECT;
        end else if (r_cnt != {CNT_W{1'b1}}) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_mask        <= '0;
      r_start       <= '0;
      r_cnt         <= '0;
      r_pass_vec    <= '0;
      r_fail_vec    <= '0;
      r_timeout_vec <= '0;
      r_cycles_last <= '0;
      r_busy        <= 1'b0;
      r_finished    <= 1'b0;
      r_all_passed  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_mask        <= w_mask_nxt;
      r_start       <= w_start_nxt;
      r_cnt         <= w_cnt_nxt;
      r_pass_vec    <= w_pass_nxt;
      r_fail_vec    <= w_fail_nxt;
      r_timeout_vec <= w_timeout_nxt;
      r_cycles_last <= w_cycles_nxt;
      r_busy        <= w_busy_nxt;
      r_finished    <= w_finished_nxt;
      r_all_passed  <= w_all_passed_nxt;
    end
  end

  assign start       = r_start;
  assign busy        = r_busy;
  assign finished    = r_finished;
  assign current_idx = r_idx;
  assign pass_vec    = r_pass_vec;
  assign fail_vec    = r_fail_vec;
  assign timeout_vec = r_timeout_vec;
  assign cycles_last = r_cycles_last;
  assign all_passed  = r_all_passed;

endmodule

// File: tb/tb_test_scheduler.sv
// Bench for test_scheduler with four channels: bench-side responders answer each start, and a queue of expected start pulses is checked.
module tb_test_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  enable_mask = '0;
  logic [3:0]  done = '0;
  logic [3:0]  pass = '0;
  logic [3:0]  start;
  logic        busy;
  logic        finished;
  logic [2:0]  current_idx;
  logic [3:0]  pass_vec;
  logic [3:0]  fail_vec;
  logic [3:0]  timeout_vec;
  logic [15:0] cycles_last;
  logic        all_passed;

  test_scheduler #(.NUM_TESTS(4), .CNT_W(16), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .run(run), .enable_mask(enable_mask),
    .done(done), .pass(pass), .start(start), .busy(busy), .finished(finished),
    .current_idx(current_idx), .pass_vec(pass_vec), .fail_vec(fail_vec),
    .timeout_vec(timeout_vec), .cycles_last(cycles_last), .all_passed(all_passed)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         tick_no = 0;
  int         cd[4];
  int         lat[4];
  logic [3:0] verdict;
  logic [3:0] hang;
  logic [3:0] inj[int];
  int         obs_q[$];
  int         exp_q[$];
  int         fin_tick;

  // One cycle: sample outputs at the falling edge, then drive the responders' done/pass.
  task automatic tick();
    @(negedge clk);
    tick_no++;
    if (start != 4'b0) obs_q.push_back(tick_no * 16 + int'(start));
    done = '0;
    pass = '0;
    for (int i = 0; i < 4; i++) begin
      if (cd[i] > 0) begin
        cd[i]--;
        if (cd[i] == 0) begin
          done[i] = 1'b1;
          pass[i] = verdict[i];
          cd[i]   = -1;
        end
      end
      if (start[i] && !hang[i]) cd[i] = lat[i];
    end
    if (inj.exists(tick_no)) begin
      done = done | inj[tick_no];
      pass = pass & ~inj[tick_no];
    end
  endtask

  task automatic setup();
    for (int i = 0; i < 4; i++) begin
      cd[i]  = -1;
      lat[i] = 3;
    end
    verdict = 4'b1111;
    hang    = 4'b0000;
    inj.delete();
    obs_q.delete();
    exp_q.delete();
    done    = '0;
    pass    = '0;
    tick_no = 0;
  endtask

  // Tick 1 is the first SELECT cycle after run is accepted.
  task automatic start_pass(input logic [3:0] m);
    enable_mask = m;
    run         = 1'b1;
    tick_no     = 0;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_finish();
    fin_tick = -1;
    for (int t = 0; t < 300; t++) begin
      if (finished) begin
        fin_tick = tick_no;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    setup();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({start, busy, finished, current_idx} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got start=%b busy=%b fin=%b idx=%0d, need all 0", start, busy, finished, current_idx);
    end
    n_checks++;
    if ({pass_vec, fail_vec, timeout_vec} !== 12'b0) begin
      n_fail++; $display("FAIL reset_vecs: got p=%b f=%b t=%b, need all 0", pass_vec, fail_vec, timeout_vec);
    end
    n_checks++;
    if ({cycles_last, all_passed} !== 17'b0) begin
      n_fail++; $display("FAIL reset_cyc: got cyc=%0d allp=%b, need 0", cycles_last, all_passed);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_all_pass();
    int e, o;
    setup();
    exp_q = '{2*16+1, 7*16+2, 12*16+4, 17*16+8};
    start_pass(4'b1111);
    wait_finish();
    n_checks++;
    if (fin_tick !== 22) begin n_fail++; $display("FAIL all_pass_fin_tick: got %0d need 22", fin_tick); end
    n_checks++;
    if (pass_vec !== 4'b1111 || fail_vec !== 4'b0000) begin
      n_fail++; $display("FAIL all_pass_vecs: got p=%b f=%b need 1111/0000", pass_vec, fail_vec);
    end
    n_checks++;
    if (all_passed !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL all_pass_flags: got allp=%b busy=%b need 1/0", all_passed, busy);
    end
    n_checks++;
    if (cycles_last !== 16'd2) begin n_fail++; $display("FAIL all_pass_cycles: got %0d need 2", cycles_last); end
    n_checks++;
    if (current_idx !== 3'd4) begin n_fail++; $display("FAIL all_pass_idx: got %0d need 4", current_idx); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL all_pass_start: got none, need tick %0d vec %0h", e / 16, e % 16);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL all_pass_start: got tick %0d vec %0h, need tick %0d vec %0h", o / 16, o % 16, e / 16, e % 16);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL all_pass_extra: got %0d extra starts, need 0", obs_q.size()); end
  endtask

  task automatic test_mask_fail();
    int e, o;
    setup();
    verdict = 4'b1011;
    exp_q = '{2*16+1, 8*16+4};
    start_pass(4'b0101);
    wait_finish();
    n_checks++;
    if (fin_tick !== 14) begin n_fail++; $display("FAIL mask_fin_tick: got %0d need 14", fin_tick); end
    n_checks++;
    if (pass_vec !== 4'b0001 || fail_vec !== 4'b0100) begin
      n_fail++; $display("FAIL mask_vecs: got p=%b f=%b need 0001/0100", pass_vec, fail_vec);
    end
    n_checks++;
    if (all_passed !== 1'b0) begin n_fail++; $display("FAIL mask_allp: got %b need 0", all_passed); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL mask_start: got none, need tick %0d vec %0h", e / 16, e % 16);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL mask_start: got tick %0d vec %0h, need tick %0d vec %0h", o / 16, o % 16, e / 16, e % 16);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL mask_extra: got %0d extra starts, need 0", obs_q.size()); end
  endtask

  // Runs from FINISH with failures recorded; an empty mask with run held must clear them and loop.
  task automatic test_empty_restart();
    setup();
    enable_mask = 4'b0000;
    run = 1'b1;
    tick();
    n_checks++;
    if (pass_vec !== 4'b0 || fail_vec !== 4'b0 || busy !== 1'b1 || current_idx !== 3'd0) begin
      n_fail++; $display("FAIL empty_accept: got p=%b f=%b busy=%b idx=%0d need 0/0/1/0", pass_vec, fail_vec, busy, current_idx);
    end
    wait_finish();
    // five cycles after the first SELECT cycle (tick 1)
    n_checks++;
    if (fin_tick !== 6) begin n_fail++; $display("FAIL empty_fin_tick: got %0d need 6", fin_tick); end
    n_checks++;
    if (all_passed !== 1'b1 || current_idx !== 3'd4) begin
      n_fail++; $display("FAIL empty_allp: got allp=%b idx=%0d need 1/4", all_passed, current_idx);
    end
    tick();
    n_checks++;
    if (finished !== 1'b0 || busy !== 1'b1 || current_idx !== 3'd0 || all_passed !== 1'b0) begin
      n_fail++; $display("FAIL empty_restart: got fin=%b busy=%b idx=%0d allp=%b need 0/1/0/0", finished, busy, current_idx, all_passed);
    end
    run = 1'b0;
    wait_finish();
    n_checks++;
    if (finished !== 1'b1 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL empty_end: got fin=%b starts=%0d need 1/0", finished, obs_q.size());
    end
  endtask

  task automatic test_spurious();
    int e, o;
    setup();
    lat[0] = 5;
    inj[1] = 4'b0001;
    inj[2] = 4'b0001;
    inj[4] = 4'b1000;
    exp_q = '{2*16+1, 11*16+8};
    start_pass(4'b1001);
    wait_finish();
    n_checks++;
    if (fin_tick !== 16) begin n_fail++; $display("FAIL spur_fin_tick: got %0d need 16", fin_tick); end
    n_checks++;
    if (pass_vec !== 4'b1001 || fail_vec !== 4'b0000 || all_passed !== 1'b1) begin
      n_fail++; $display("FAIL spur_vecs: got p=%b f=%b allp=%b need 1001/0000/1", pass_vec, fail_vec, all_passed);
    end
    n_checks++;
    if (cycles_last !== 16'd2) begin n_fail++; $display("FAIL spur_cycles: got %0d need 2", cycles_last); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL spur_start: got none, need tick %0d vec %0h", e / 16, e % 16);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL spur_start: got tick %0d vec %0h, need tick %0d vec %0h", o / 16, o % 16, e / 16, e % 16);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int e, o;
    logic [15:0] cyc18;
    logic [3:0]  tmo18;
    setup();
    hang[1] = 1'b1;
    cyc18 = '1;
    tmo18 = '1;
`ifdef TEST_SCHEDULER_TIMEOUT_EN
    exp_q = '{2*16+1, 7*16+2, 19*16+4};
    start_pass(4'b0111);
    fin_tick = -1;
    for (int t = 0; t < 300; t++) begin
      if (tick_no == 18) begin
        cyc18 = cycles_last;
        tmo18 = timeout_vec;
      end
      if (finished) begin
        fin_tick = tick_no;
        break;
      end
      tick();
    end
    n_checks++;
    if (cyc18 !== 16'd9 || tmo18 !== 4'b0010) begin
      n_fail++; $display("FAIL tmo_record: got cyc=%0d tmo=%b need 9/0010", cyc18, tmo18);
    end
    n_checks++;
    if (fin_tick !== 25) begin n_fail++; $display("FAIL tmo_fin_tick: got %0d need 25", fin_tick); end
    n_checks++;
    if (timeout_vec !== 4'b0010 || fail_vec !== 4'b0010 || pass_vec !== 4'b0101 || all_passed !== 1'b0) begin
      n_fail++; $display("FAIL tmo_vecs: got t=%b f=%b p=%b allp=%b need 0010/0010/0101/0", timeout_vec, fail_vec, pass_vec, all_passed);
    end
`else
    exp_q = '{3*16+2};
    start_pass(4'b0010);
    for (int t = 0; t < 40; t++) tick();
    n_checks++;
    if (busy !== 1'b1 || finished !== 1'b0 || current_idx !== 3'd1 || timeout_vec !== 4'b0) begin
      n_fail++; $display("FAIL hang_wait: got busy=%b fin=%b idx=%0d tmo=%b need 1/0/1/0000", busy, finished, current_idx, timeout_vec);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL tmo_start: got none, need tick %0d vec %0h", e / 16, e % 16);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL tmo_start: got tick %0d vec %0h, need tick %0d vec %0h", o / 16, o % 16, e / 16, e % 16);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e, o;
    setup();
    exp_q = '{2*16+1, 7*16+2, 12*16+4};
    start_pass(4'b1111);
    for (int t = 0; t < 50 && tick_no < 13; t++) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({start, busy, finished, current_idx, all_passed} !== 10'b0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got start=%b busy=%b fin=%b idx=%0d allp=%b need 0", start, busy, finished, current_idx, all_passed);
    end
    n_checks++;
    if ({pass_vec, fail_vec, timeout_vec} !== 12'b0 || cycles_last !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_vecs: got p=%b f=%b t=%b cyc=%0d need 0", pass_vec, fail_vec, timeout_vec, cycles_last);
    end
    reset = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    n_checks++;
    if (busy !== 1'b0 || finished !== 1'b0 || current_idx !== 3'd0) begin
      n_fail++; $display("FAIL rst_mid_idle: got busy=%b fin=%b idx=%0d need 0/0/0", busy, finished, current_idx);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL rst_mid_start: got none, need tick %0d vec %0h", e / 16, e % 16);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL rst_mid_start: got tick %0d vec %0h, need tick %0d vec %0h", o / 16, o % 16, e / 16, e % 16);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_extra: got %0d starts after reset, need 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_mask_fail();
    test_empty_restart();
    test_spurious();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
